// File: rtl/traffic_light_timer_if.sv
// Timer/FSM handshake bundle for traffic_light_timer.
// Optional time_bcd signal is present only when TRAFFIC_TIMER_BCD_EN is defined.
interface traffic_light_timer_if #(
    parameter int unsigned CNT_W = 7
);
    logic [1:0]       current_state;
    logic             timer_load;
    logic             timer_zero;
    logic [CNT_W-1:0] time_left;
    logic             tick_1hz;
`ifdef TRAFFIC_TIMER_BCD_EN
    logic [7:0]       time_bcd;

    // FSM side drives state/load and observes the countdown.
    modport master (
        output current_state, timer_load,
        input  timer_zero, time_left, tick_1hz, time_bcd
    );

    // Timer side.
    modport slave (
        input  current_state, timer_load,
        output timer_zero, time_left, tick_1hz, time_bcd
    );
`else
    // FSM side drives state/load and observes the countdown.
    modport master (
        output current_state, timer_load,
        input  timer_zero, time_left, tick_1hz
    );

    // Timer side.
    modport slave (
        input  current_state, timer_load,
        output timer_zero, time_left, tick_1hz
    );
`endif
endinterface

// File: rtl/traffic_light_timer.sv
// Phase countdown timer for the traffic light FSM.
// A prescaler divides clk down to a 1 s tick; the seconds counter loads the
// duration of the current phase on timer_load and counts down on each tick,
// pulsing timer_zero on the tick that ends the phase.
// Optional feature: define TRAFFIC_TIMER_BCD_EN to add a registered BCD copy
// of time_left on time_bcd.
module traffic_light_timer #(
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned GREEN_TIME  = 15,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned RED_TIME    = 18,
    parameter int unsigned CNT_W       = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    traffic_light_timer_if.slave tmr
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PrescMax  = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GreenDur  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] YellowDur = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] RedDur    = CNT_W'(RED_TIME);

    // Parameter sanity checks at elaboration.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (GREEN_TIME == 0 || YELLOW_TIME == 0 || RED_TIME == 0) begin : g_bad_dur_zero
        $error("phase durations must be non-zero");
    end
    if (GREEN_TIME > 99 || YELLOW_TIME > 99 || RED_TIME > 99) begin : g_bad_dur_big
        $error("phase durations must be <= 99");
    end
    if (CNT_W < 7) begin : g_bad_cnt_w
        $error("CNT_W must be wide enough to hold 99");
    end

    typedef enum logic [1:0] {
        StGreen   = 2'b00,
        StYellow  = 2'b01,
        StRed     = 2'b10,
        StIllegal = 2'b11
    } light_e;

    light_e           light;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic [CNT_W-1:0] load_dur;
    logic             tick;

    assign light = light_e'(tmr.current_state);
    assign tick  = (presc_q == PrescMax);

    // Duration lookup; the illegal encoding falls back to RED as the safe phase.
    always_comb begin
        load_dur = RedDur;
        unique case (light)
            StGreen:   load_dur = GreenDur;
            StYellow:  load_dur = YellowDur;
            StRed:     load_dur = RedDur;
            StIllegal: load_dur = RedDur;
        endcase
    end

    // Next state: load beats decrement; the counter sticks at zero until reloaded.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        left_d  = left_q;
        if (tmr.timer_load) begin
            presc_d = '0;
            left_d  = load_dur;
        end else if (tick && (left_q != '0)) begin
            left_d = left_q - CNT_W'(1);
        end
    end

    // Prescaler and seconds counter; reset matches the FSM's GREEN reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            left_q  <= GreenDur;
        end else begin
            presc_q <= presc_d;
            left_q  <= left_d;
        end
    end

    assign tmr.tick_1hz   = tick;
    assign tmr.time_left  = left_q;
    assign tmr.timer_zero = tick && (left_q == CNT_W'(1)) && !tmr.timer_load;

`ifdef TRAFFIC_TIMER_BCD_EN
    function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] tens;
        logic [CNT_W-1:0] units;
        tens  = v / CNT_W'(10);
        units = v % CNT_W'(10);
        return {tens[3:0], units[3:0]};
    endfunction

    logic [7:0] bcd_q;

    // BCD display copy, one cycle behind time_left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= to_bcd(GreenDur);
        end else begin
            bcd_q <= to_bcd(left_q);
        end
    end

    assign tmr.time_bcd = bcd_q;
`endif

endmodule
